// File: rtl/mlkem_pkg.sv
// Shared ML-KEM constants and the encode-path state type.
// Also holds the width-validity and coefficient-mask helpers used by the packer.
package mlkem_pkg;

  localparam int N      = 256;
  localparam int Q      = 3329;
  localparam int D_MAX  = 12;
  localparam int D_W    = 4;
  localparam int ACC_W  = 20;
  localparam int CNT_W  = 5;
  localparam int CCNT_W = 9;
  localparam int BCNT_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic d_valid(input logic [D_W-1:0] d);
    return (d != '0) && (d <= D_W'(D_MAX));
  endfunction

  // d = D_MAX wraps the shifted one to zero, so the subtraction yields all ones.
  function automatic logic [D_MAX-1:0] coeff_mask(input logic [D_W-1:0] d);
    return (D_MAX'(1) << d) - D_MAX'(1);
  endfunction

endpackage

// File: rtl/byte_encode_packer_if.sv
// Coefficient-in / byte-out handshake bundle for the ByteEncode packer.
// The slave modport is the packer's view; master is the producer/consumer side.
interface byte_encode_packer_if;
  import mlkem_pkg::*;

  logic [D_W-1:0]   d_i;
  logic [D_MAX-1:0] coeff_i;
  logic             coeff_valid_i;
  logic             coeff_ready_o;
  logic [7:0]       byte_o;
  logic             byte_valid_o;
  logic             byte_ready_i;
  logic             byte_last_o;
  logic             busy_o;

  modport slave (
    input  d_i, coeff_i, coeff_valid_i, byte_ready_i,
    output coeff_ready_o, byte_o, byte_valid_o, byte_last_o, busy_o
  );

  modport master (
    output d_i, coeff_i, coeff_valid_i, byte_ready_i,
    input  coeff_ready_o, byte_o, byte_valid_o, byte_last_o, busy_o
  );

endinterface

// File: rtl/byte_encode_packer.sv
// Streaming ByteEncode_d packer: d-bit coefficients in, LSB-first packed bytes out.
//
// state | meaning
// IDLE  | waiting for first coefficient; d_i is sampled on that acceptance
// RUN   | accepting coefficients 2..N of the polynomial
// DRAIN | all coefficients taken; emitting remaining bytes until the last one
module byte_encode_packer
  import mlkem_pkg::*;
(
  input logic               clk_i,
  input logic               rst_i,
  byte_encode_packer_if.slave bus
);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CCNT_W-1:0]   ccnt_q, ccnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [D_W-1:0]      d_q, d_d;

  logic                byte_valid;
  logic                byte_last;
  logic                pop;
  logic                push;
  logic                ready;
  logic                d_ok;
  logic [CNT_W-1:0]    cnt_eff;
  logic [ACC_W-1:0]    acc_eff;
  logic [D_W-1:0]      d_eff;
  logic [BCNT_W-1:0]   last_idx;
  logic [ACC_W-1:0]    insert;

  // Readiness counts the byte leaving this cycle, so d <= 8 streams at full rate.
  always_comb begin
    byte_valid = (cnt_q >= CNT_W'(8));
    pop        = byte_valid && bus.byte_ready_i;
    cnt_eff    = pop ? (cnt_q - CNT_W'(8)) : cnt_q;
    acc_eff    = pop ? (acc_q >> 8) : acc_q;
    d_eff      = (state_q == IDLE) ? bus.d_i : d_q;
    d_ok       = (state_q != IDLE) || d_valid(bus.d_i);
    ready      = !rst_i && (state_q != DRAIN) && (cnt_eff < CNT_W'(8)) && d_ok;
    push       = bus.coeff_valid_i && ready;
    last_idx   = {d_q, 5'b0} - BCNT_W'(1);
    byte_last  = byte_valid && (state_q == DRAIN) && (bcnt_q == last_idx);
    insert     = ACC_W'(bus.coeff_i & coeff_mask(d_eff)) << cnt_eff;
  end

  assign bus.coeff_ready_o = ready;
  assign bus.byte_o        = acc_q[7:0];
  assign bus.byte_valid_o  = byte_valid;
  assign bus.byte_last_o   = byte_last;
  assign bus.busy_o        = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_eff;
    cnt_d   = cnt_eff;
    ccnt_d  = ccnt_q;
    bcnt_d  = pop ? (bcnt_q + BCNT_W'(1)) : bcnt_q;
    d_d     = d_q;

    if (push) begin
      acc_d = acc_eff | insert;
      cnt_d = cnt_eff + CNT_W'(d_eff);
    end

    case (state_q)
      IDLE: begin
        if (push) begin
          d_d     = bus.d_i;
          ccnt_d  = CCNT_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (push) begin
          ccnt_d = ccnt_q + CCNT_W'(1);
          if (ccnt_q == CCNT_W'(N - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // 256*d bits is a whole number of bytes, so nothing is left behind.
        if (pop && byte_last) begin
          state_d = IDLE;
          ccnt_d  = '0;
          bcnt_d  = '0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ccnt_q  <= '0;
      bcnt_q  <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ccnt_q  <= ccnt_d;
      bcnt_q  <= bcnt_d;
      d_q     <= d_d;
    end
  end

endmodule

// File: tb/tb_byte_encode_packer.sv
// Directed bench for byte_encode_packer: bit-level reference packing, handshake
// stalls, invalid widths and mid-polynomial reset.
module tb_byte_encode_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  byte_encode_packer_if bus();

  byte_encode_packer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] coeffs [256];
  logic [7:0]  exp_b  [384];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int d);
    int bp;
    bp = 0;
    for (int i = 0; i < 384; i++) exp_b[i] = 8'h00;
    for (int n = 0; n < 256; n++)
      for (int k = 0; k < d; k++) begin
        exp_b[bp / 8][bp % 8] = coeffs[n][k];
        bp++;
      end
  endtask

  task automatic run_poly(input int d, input bit rnd_v, input bit rnd_r, input bit rnd_d,
                          output int last_acc, output int first_v, output logic [7:0] first_byte);
    int pi, bi, cyc, nb;
    bit hold, cf, bf;
    logic [7:0] hb;
    logic hl;
    build_exp(d);
    nb = d * 32;
    pi = 0; bi = 0; cyc = 0; hold = 0; hb = 0; hl = 0;
    last_acc = -1; first_v = -1; first_byte = 8'h00;
    while (bi < nb && cyc < 20000) begin
      @(negedge clk);
      bus.coeff_valid_i = (pi < 256) && (!rnd_v || $urandom_range(0, 1) == 1);
      bus.coeff_i       = (pi < 256) ? coeffs[pi] : 12'h000;
      bus.d_i           = (rnd_d && pi > 0) ? 4'($urandom_range(0, 15)) : 4'(d);
      bus.byte_ready_i  = !rnd_r || ($urandom_range(0, 1) == 1);
      #1;
      if (hold) begin
        check_val("hold_valid", 32'(bus.byte_valid_o), 32'd1);
        check_val("hold_byte", 32'(bus.byte_o), 32'(hb));
        check_val("hold_last", 32'(bus.byte_last_o), 32'(hl));
      end
      if (bus.byte_valid_o) begin
        if (first_v < 0) begin
          first_v    = cyc;
          first_byte = bus.byte_o;
        end
        check_val("byte", 32'(bus.byte_o), 32'(exp_b[bi]));
        check_val("last", 32'(bus.byte_last_o), 32'(bi == nb - 1));
      end
      cf = bus.coeff_valid_i && bus.coeff_ready_o;
      bf = bus.byte_valid_o && bus.byte_ready_i;
      hold = bus.byte_valid_o && !bus.byte_ready_i;
      hb = bus.byte_o;
      hl = bus.byte_last_o;
      if (bf) begin
        if (bi == nb - 1) check_val("busy_at_last", 32'(bus.busy_o), 32'd1);
        bi++;
      end
      if (cf) begin
        last_acc = cyc;
        pi++;
      end
      cyc++;
    end
    if (bi < nb) check_val("timeout_bytes", 32'(bi), 32'(nb));
    check_val("ncoeffs", 32'(pi), 32'd256);
    @(negedge clk);
    bus.coeff_valid_i = 1'b0;
    bus.byte_ready_i  = 1'b1;
    #1;
    check_val("busy_after", 32'(bus.busy_o), 32'd0);
    check_val("valid_after", 32'(bus.byte_valid_o), 32'd0);
  endtask

  initial begin
    int la, fv, cnt, guard;
    logic [7:0] fb;

    rst = 1'b1;
    bus.d_i = 4'd0;
    bus.coeff_i = '0;
    bus.coeff_valid_i = 1'b0;
    bus.byte_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.coeff_valid_i = 1'b1;
    bus.d_i = 4'd4;
    #1;
    check_val("rst_ready", 32'(bus.coeff_ready_o), 32'd0);
    check_val("rst_valid", 32'(bus.byte_valid_o), 32'd0);
    check_val("rst_last", 32'(bus.byte_last_o), 32'd0);
    check_val("rst_busy", 32'(bus.busy_o), 32'd0);
    check_val("rst_byte", 32'(bus.byte_o), 32'd0);
    @(negedge clk);
    bus.coeff_valid_i = 1'b0;
    rst = 1'b0;

    // d=1: alternating 1,0 gives 0x55 bytes at one coefficient per cycle
    for (int i = 0; i < 256; i++) coeffs[i] = (i % 2 == 0) ? 12'h001 : 12'h000;
    run_poly(1, 0, 0, 0, la, fv, fb);
    check_val("d1_first_byte", 32'(fb), 32'h55);
    check_val("d1_first_valid_cyc", 32'(fv), 32'd8);
    check_val("d1_last_accept_cyc", 32'(la), 32'd255);

    // d=12: 0x123, 0x456 -> 23 61 45; 2-of-3 input cadence
    for (int i = 0; i < 256; i++) coeffs[i] = 12'h000;
    coeffs[0] = 12'h123;
    coeffs[1] = 12'h456;
    run_poly(12, 0, 0, 0, la, fv, fb);
    check_val("d12_first_byte", 32'(fb), 32'h23);
    check_val("d12_first_valid_cyc", 32'(fv), 32'd1);
    check_val("d12_last_accept_cyc", 32'(la), 32'd382);

    // d=4 with upper bits set; they must be masked off
    for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom_range(0, 4095));
    coeffs[0] = 12'hFFA;
    coeffs[1] = 12'hFF5;
    run_poly(4, 0, 0, 0, la, fv, fb);
    check_val("d4_first_byte", 32'(fb), 32'h5A);

    // d=10, random valid/ready and d_i wandering after latch
    for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom_range(0, 4095));
    run_poly(10, 1, 1, 1, la, fv, fb);

    // invalid widths in IDLE
    for (int j = 0; j < 2; j++) begin
      repeat (20) begin
        @(negedge clk);
        bus.d_i = (j == 0) ? 4'd0 : 4'd13;
        bus.coeff_valid_i = 1'b1;
        bus.byte_ready_i = 1'b1;
        #1;
        check_val("bad_d_ready", 32'(bus.coeff_ready_o), 32'd0);
        check_val("bad_d_busy", 32'(bus.busy_o), 32'd0);
      end
    end

    // d=11, reset after 100 coefficients
    for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom_range(0, 4095));
    cnt = 0;
    guard = 0;
    while (cnt < 100 && guard < 1000) begin
      @(negedge clk);
      bus.d_i = 4'd11;
      bus.coeff_i = coeffs[cnt];
      bus.coeff_valid_i = 1'b1;
      bus.byte_ready_i = 1'b1;
      #1;
      if (bus.coeff_valid_i && bus.coeff_ready_o) cnt++;
      guard++;
    end
    check_val("d11_accepted", 32'(cnt), 32'd100);
    @(negedge clk);
    rst = 1'b1;
    bus.coeff_valid_i = 1'b1;
    #1;
    check_val("midrst_ready", 32'(bus.coeff_ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.coeff_valid_i = 1'b0;
    bus.d_i = 4'd5;
    #1;
    check_val("midrst_valid", 32'(bus.byte_valid_o), 32'd0);
    check_val("midrst_last", 32'(bus.byte_last_o), 32'd0);
    check_val("midrst_busy", 32'(bus.busy_o), 32'd0);
    check_val("midrst_byte", 32'(bus.byte_o), 32'd0);
    check_val("midrst_ready_after", 32'(bus.coeff_ready_o), 32'd1);

    for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom_range(0, 4095));
    run_poly(5, 0, 0, 0, la, fv, fb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
